// File: rtl/port_alloc_ctrl_pkg.sv
// Shared constants for the router output-port allocator.
// Port indices, port counts and the slot-to-input rotation helper.
package port_alloc_ctrl_pkg;

    localparam int NUM_PORT = 5;
    localparam int NUM_NET  = 4;
    localparam int PW       = NUM_PORT * NUM_PORT;

    localparam int PORT_W = 0;
    localparam int PORT_E = 1;
    localparam int PORT_S = 2;
    localparam int PORT_N = 3;
    localparam int PORT_L = 4;

    localparam logic [NUM_PORT-1:0] NET_MASK = 5'b01111;

    // Input served in priority slot k: network slots rotate from ptr,
    // the last slot is always local injection.
    function automatic logic [2:0] slot_port(input logic [1:0] ptr,
                                             input int k);
        if (k >= NUM_NET) return 3'(PORT_L);
        return {1'b0, ptr + 2'(k)};
    endfunction

endpackage

// File: rtl/port_alloc_ctrl_if.sv
// Request/grant bundle between route-compute stages and the allocator.
// master: req_valid, prod_vec out; slave: grant, deflected, stall, rr_ptr out.
interface port_alloc_ctrl_if;
    import port_alloc_ctrl_pkg::*;

    logic [NUM_PORT-1:0] req_valid;
    logic [PW-1:0]       prod_vec;
    logic [PW-1:0]       grant;
    logic [NUM_PORT-1:0] deflected;
    logic [NUM_PORT-1:0] stall;
    logic [1:0]          rr_ptr;

    modport master (
        output req_valid, prod_vec,
        input  grant, deflected, stall, rr_ptr
    );

    modport slave (
        input  req_valid, prod_vec,
        output grant, deflected, stall, rr_ptr
    );

endinterface

// File: rtl/port_alloc_ctrl_first_free_sel.sv
// Lowest-set-bit picker over a 5-bit port mask.
// Ports: mask in; sel one-hot lowest set bit (zero if none); found flag.
module first_free_sel
    import port_alloc_ctrl_pkg::*;
(
    input  logic [NUM_PORT-1:0] mask,
    output logic [NUM_PORT-1:0] sel,
    output logic                found
);

    assign sel   = mask & (-mask);
    assign found = |mask;

endmodule

// File: rtl/port_alloc_ctrl.sv
// Output-port allocator: rotating priority, deflection, registered grants.
// Ports: clk, reset (sync, active-high), bus (port_alloc_ctrl_if.slave).
// Option: define PORT_ALLOC_DEFLECT_EN to deflect blocked network flits.
module port_alloc_ctrl
    import port_alloc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    port_alloc_ctrl_if.slave bus
);

    logic [1:0]          rr_q;
    logic [PW-1:0]       grant_q;
    logic [PW-1:0]       grant_d;
    logic [NUM_PORT-1:0] defl_q;
    logic [NUM_PORT-1:0] defl_d;
    logic [NUM_PORT-1:0] stall_q;
    logic [NUM_PORT-1:0] stall_d;
    logic                net_hit;

    // One slot per priority position; the free mask ripples slot to slot.
    for (genvar k = 0; k < NUM_PORT; k++) begin : g_slot
        logic [2:0]          idx;
        logic                vld;
        logic [NUM_PORT-1:0] pv;
        logic [NUM_PORT-1:0] free_in;
        logic [NUM_PORT-1:0] pick_p;
        logic                found_p;
        logic [NUM_PORT-1:0] gnt;
        logic                defl;
        logic                stl;
        logic [PW-1:0]       g_vec;
        logic [NUM_PORT-1:0] s_vec;
        logic [NUM_PORT-1:0] d_vec;

        assign idx = slot_port(rr_q, k);
        assign vld = bus.req_valid[idx];
        assign pv  = bus.prod_vec[idx*NUM_PORT +: NUM_PORT];

        if (k == 0) begin : g_head
            assign free_in = '1;
        end else begin : g_link
            assign free_in = g_slot[k-1].g_fwd.free_out;
        end

        first_free_sel u_prod (
            .mask  (pv & free_in),
            .sel   (pick_p),
            .found (found_p)
        );

        if (k < NUM_NET) begin : g_net
`ifdef PORT_ALLOC_DEFLECT_EN
            logic [NUM_PORT-1:0] pick_d;
            logic                found_d;

            // Deflection never targets the local ejection port.
            first_free_sel u_defl (
                .mask  (free_in & NET_MASK),
                .sel   (pick_d),
                .found (found_d)
            );

            assign gnt  = !vld   ? '0 :
                          found_p ? pick_p : pick_d;
            assign defl = vld & ~found_p & found_d;
`else
            assign gnt  = (vld && found_p) ? pick_p : '0;
            assign defl = 1'b0;
`endif
        end else begin : g_inj
            assign gnt  = (vld && found_p) ? pick_p : '0;
            assign defl = 1'b0;
        end

        if (k < NUM_PORT - 1) begin : g_fwd
            logic [NUM_PORT-1:0] free_out;
            assign free_out = free_in & ~gnt;
        end

        assign stl   = vld & ~(|gnt);
        assign g_vec = PW'(gnt) << (idx * NUM_PORT);
        assign s_vec = NUM_PORT'(stl) << idx;
        assign d_vec = NUM_PORT'(defl) << idx;
    end

    assign grant_d = g_slot[0].g_vec | g_slot[1].g_vec |
                     g_slot[2].g_vec | g_slot[3].g_vec |
                     g_slot[4].g_vec;

    assign stall_d = g_slot[0].s_vec | g_slot[1].s_vec |
                     g_slot[2].s_vec | g_slot[3].s_vec |
                     g_slot[4].s_vec;

    assign defl_d  = g_slot[0].d_vec | g_slot[1].d_vec |
                     g_slot[2].d_vec | g_slot[3].d_vec |
                     g_slot[4].d_vec;

    assign net_hit = |{g_slot[0].gnt, g_slot[1].gnt,
                       g_slot[2].gnt, g_slot[3].gnt};

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= '0;
            defl_q  <= '0;
            stall_q <= '0;
            rr_q    <= '0;
        end else begin
            grant_q <= grant_d;
            defl_q  <= defl_d;
            stall_q <= stall_d;
            if (net_hit) rr_q <= rr_q + 2'd1;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.deflected = defl_q;
    assign bus.stall     = stall_q;
    assign bus.rr_ptr    = rr_q;

endmodule
